// File: rtl/debug_ram_pkg.sv
// Shared constants for the 1024x8 debug RAM: depth and address width (also used by the VGA viewer),
// the writer's command opcodes and its FSM state encoding.
package debug_ram_pkg;

  localparam int unsigned DEBUG_RAM_DEPTH = 1024;
  localparam int unsigned ADDR_W          = $clog2(DEBUG_RAM_DEPTH);

  localparam logic [7:0] OP_SET_ADDR = 8'h01;
  localparam logic [7:0] OP_WRITE    = 8'h02;
  localparam logic [7:0] OP_FILL     = 8'h03;
  localparam logic [7:0] OP_CLEAR    = 8'h04;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_W_COUNT,
    S_W_DATA,
    S_F_VAL,
    S_F_COUNT,
    S_FILLING,
    S_CLEARING
  } wr_state_t;

  // Bytes are accepted everywhere except while the block generates writes on its own.
  function automatic logic takes_bytes(input wr_state_t s);
    return (s != S_FILLING) && (s != S_CLEARING);
  endfunction

  // States that sit part-way through a packet waiting for an operand byte.
  function automatic logic waits_operand(input wr_state_t s);
    return (s != S_IDLE) && takes_bytes(s);
  endfunction

  // Count byte of WRITE/FILL: 0 encodes a full 256-byte run.
  function automatic logic [8:0] burst_len(input logic [7:0] n);
    return (n == 8'd0) ? 9'd256 : {1'b0, n};
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/debug_ram_writer.sv
// Byte-stream command parser driving port a of the debug RAM (set address, burst write, fill, clear).
// Optional DEBUG_WR_TIMEOUT_EN aborts partial packets after TIMEOUT_CYCLES idle cycles.
module debug_ram_writer
  import debug_ram_pkg::*;
#(
  parameter int unsigned ADDR_W         = debug_ram_pkg::ADDR_W,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              ram_en_a,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [DATA_W-1:0] ram_data_a,
  output logic              busy,
  output logic [7:0]        err_count
);

  localparam int unsigned HI_W = ADDR_W - DATA_W;

  wr_state_t         state;
  logic [ADDR_W-1:0] ptr;
  logic [8:0]        count;
  logic [HI_W-1:0]   addr_hi;
  logic [DATA_W-1:0] fill_val;
  logic              accept;
  logic              timeout;

  // Both are pure decodes of the state register, so they change only on clk.
  assign in_ready = takes_bytes(state);
  assign busy     = (state != S_IDLE);
  assign accept   = in_valid && in_ready;

`ifdef DEBUG_WR_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] idle_cnt;

  always_ff @(posedge clk) begin
    if (rst || accept || timeout || !waits_operand(state)) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign timeout = waits_operand(state) && !accept &&
                   (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  // Partial packets wait indefinitely; the parameter stays referenced so both builds share one interface.
  assign timeout = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ptr        <= '0;
      count      <= '0;
      addr_hi    <= '0;
      fill_val   <= '0;
      ram_en_a   <= 1'b0;
      ram_addr_a <= '0;
      ram_data_a <= '0;
      err_count  <= '0;
    end else begin
      ram_en_a <= 1'b0;
      if (timeout) begin
        state     <= S_IDLE;
        err_count <= sat_inc(err_count);
      end else begin
        case (state)
          S_IDLE: begin
            if (accept) begin
              case (in_data[7:0])
                OP_SET_ADDR: state <= S_ADDR_HI;
                OP_WRITE:    state <= S_W_COUNT;
                OP_FILL:     state <= S_F_VAL;
                OP_CLEAR: begin
                  // The clear sweep walks ptr itself; a full wrap leaves it back at 0.
                  state <= S_CLEARING;
                  ptr   <= '0;
                end
                default:     err_count <= sat_inc(err_count);
              endcase
            end
          end

          S_ADDR_HI: begin
            if (accept) begin
              addr_hi <= in_data[HI_W-1:0];
              state   <= S_ADDR_LO;
            end
          end

          S_ADDR_LO: begin
            if (accept) begin
              ptr   <= {addr_hi, in_data};
              state <= S_IDLE;
            end
          end

          S_W_COUNT: begin
            if (accept) begin
              count <= burst_len(in_data[7:0]);
              state <= S_W_DATA;
            end
          end

          S_W_DATA: begin
            if (accept) begin
              ram_en_a   <= 1'b1;
              ram_addr_a <= ptr;
              ram_data_a <= in_data;
              ptr        <= ptr + 1'b1;
              count      <= count - 1'b1;
              if (count == 9'd1) begin
                state <= S_IDLE;
              end
            end
          end

          S_F_VAL: begin
            if (accept) begin
              fill_val <= in_data;
              state    <= S_F_COUNT;
            end
          end

          S_F_COUNT: begin
            if (accept) begin
              count <= burst_len(in_data[7:0]);
              state <= S_FILLING;
            end
          end

          S_FILLING: begin
            ram_en_a   <= 1'b1;
            ram_addr_a <= ptr;
            ram_data_a <= fill_val;
            ptr        <= ptr + 1'b1;
            count      <= count - 1'b1;
            if (count == 9'd1) begin
              state <= S_IDLE;
            end
          end

          S_CLEARING: begin
            ram_en_a   <= 1'b1;
            ram_addr_a <= ptr;
            ram_data_a <= '0;
            ptr        <= ptr + 1'b1;
            if (ptr == '1) begin
              state <= S_IDLE;
            end
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_debug_ram_writer.sv
// Self-checking bench for debug_ram_writer: directed command packets plus randomized traffic,
// checked cycle by cycle against a command-level model of the expected RAM writes.
module tb_debug_ram_writer;

  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 1024;

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data  = '0;
  logic          in_ready;
  logic          ram_en_a;
  logic [AW-1:0] ram_addr_a;
  logic [DW-1:0] ram_data_a;
  logic          busy;
  logic [7:0]    err_count;

  always #5 clk = ~clk;

  debug_ram_writer #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .ram_en_a   (ram_en_a),
    .ram_addr_a (ram_addr_a),
    .ram_data_a (ram_data_a),
    .busy       (busy),
    .err_count  (err_count)
  );

  typedef struct {
    int unsigned cyc;
    int unsigned addr;
    int unsigned data;
  } wr_t;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc   = 0;

  // Model state: expected writes (cycle, address, data), pointer, error count,
  // window of cycles with in_ready low, and the last written address/data.
  wr_t         exp_q[$];
  logic [7:0]  payload[$];
  int unsigned mptr      = 0;
  int unsigned exp_err   = 0;
  int unsigned blk_lo    = 1;
  int unsigned blk_hi    = 0;
  int unsigned held_addr = 0;
  int unsigned held_data = 0;
  bit          mon_en    = 1'b0;
  bit          rand_gap  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      logic due;
      wr_t  e;
      due = 1'b0;
      if (exp_q.size() != 0) begin
        if (exp_q[0].cyc == cyc) due = 1'b1;
      end
      check("ram_en_a", 32'(ram_en_a), 32'(due));
      if (due) begin
        e = exp_q.pop_front();
        if (ram_en_a) begin
          check("wr_addr", 32'(ram_addr_a), e.addr);
          check("wr_data", 32'(ram_data_a), e.data);
        end
        held_addr = e.addr;
        held_data = e.data;
      end else begin
        check("hold_addr", 32'(ram_addr_a), held_addr);
        check("hold_data", 32'(ram_data_a), held_data);
      end
      check("in_ready", 32'(in_ready), 32'(!(cyc >= blk_lo && cyc <= blk_hi)));
    end
  end

  // Called just after a rising edge; returns with the byte accepted and stamp = cycle of acceptance.
  task automatic send_byte(input logic [7:0] b, output int unsigned stamp);
    int unsigned guard;
    guard = 0;
    if (rand_gap) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && guard < 3000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!in_ready) check("ready_wait", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    stamp    = cyc;
  endtask

  task automatic cmd_set_addr(input logic [7:0] hi, input logic [7:0] lo);
    int unsigned s;
    send_byte(8'h01, s);
    check("busy_sa_op", 32'(busy), 32'd1);
    send_byte(hi, s);
    send_byte(lo, s);
    check("busy_sa_end", 32'(busy), 32'd0);
    mptr = ((32'(hi) & 3) << 8) | 32'(lo);
  endtask

  task automatic cmd_write(input logic [7:0] n_code);
    int unsigned s;
    int unsigned n;
    logic [7:0]  d;
    n = (n_code == 0) ? 256 : 32'(n_code);
    send_byte(8'h02, s);
    check("busy_wr_op", 32'(busy), 32'd1);
    send_byte(n_code, s);
    for (int unsigned i = 0; i < n; i++) begin
      d = (i < payload.size()) ? payload[i] : 8'($urandom);
      send_byte(d, s);
      exp_q.push_back('{s, mptr, 32'(d)});
      mptr = (mptr + 1) % DEPTH;
    end
    payload.delete();
    check("busy_wr_end", 32'(busy), 32'd0);
  endtask

  // abort_at != 0 asserts rst in that FILLING cycle (1-based).
  task automatic cmd_fill(input logic [7:0] v, input logic [7:0] n_code, input int unsigned abort_at);
    int unsigned c;
    int unsigned n;
    int unsigned nw;
    n = (n_code == 0) ? 256 : 32'(n_code);
    send_byte(8'h03, c);
    send_byte(v, c);
    send_byte(n_code, c);
    nw = (abort_at != 0) ? abort_at - 1 : n;
    for (int unsigned i = 0; i < nw; i++) exp_q.push_back('{c + 1 + i, (mptr + i) % DEPTH, 32'(v)});
    blk_lo = c;
    blk_hi = (abort_at != 0) ? c + abort_at - 1 : c + n - 1;
    if (abort_at != 0) begin
      repeat (abort_at - 1) begin
        @(posedge clk);
        #1;
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      mptr      = 0;
      exp_err   = 0;
      held_addr = 0;
      held_data = 0;
      check("rst_ram_en", 32'(ram_en_a), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(err_count), 32'd0);
      check("rst_ready", 32'(in_ready), 32'd1);
      rst = 1'b0;
    end else begin
      mptr = (mptr + n) % DEPTH;
    end
  endtask

  task automatic cmd_clear(output int unsigned c);
    send_byte(8'h04, c);
    check("busy_clr", 32'(busy), 32'd1);
    for (int unsigned i = 0; i < DEPTH; i++) exp_q.push_back('{c + 1 + i, i, 0});
    blk_lo = c;
    blk_hi = c + DEPTH - 1;
    mptr   = 0;
  endtask

  task automatic cmd_bad(input logic [7:0] op, output int unsigned s);
    send_byte(op, s);
    exp_err = (exp_err >= 255) ? 255 : exp_err + 1;
    check("err_count", 32'(err_count), exp_err);
    check("busy_bad", 32'(busy), 32'd0);
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c;
    int unsigned s;
    int unsigned k;
    int unsigned guard;
    logic [7:0]  op;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ram_en0", 32'(ram_en_a), 32'd0);
    check("rst_addr0", 32'(ram_addr_a), 32'd0);
    check("rst_data0", 32'(ram_data_a), 32'd0);
    check("rst_busy0", 32'(busy), 32'd0);
    check("rst_err0", 32'(err_count), 32'd0);
    check("rst_ready0", 32'(in_ready), 32'd1);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Basic burst write at 0x010.
    cmd_set_addr(8'h00, 8'h10);
    payload = '{8'hAA, 8'hBB, 8'hCC};
    cmd_write(8'h03);

    // Burst crossing the top of the RAM.
    cmd_set_addr(8'h03, 8'hFE);
    payload = '{8'h11, 8'h22, 8'h33};
    cmd_write(8'h03);
    check("ptr_wrap", mptr, 32'd1);

    // 256-long fill.
    cmd_fill(8'h5A, 8'h00, 0);

    // Clear, with an unknown opcode held on the stream during the sweep.
    cmd_clear(c);
    cmd_bad(8'h07, s);
    check("held_op_cycle", s, c + DEPTH + 1);

    // Reset in the 100th FILLING cycle.
    cmd_set_addr(8'h01, 8'h23);
    cmd_fill(8'hC3, 8'hC8, 100);
    payload = '{8'h9D};
    cmd_write(8'h01);

`ifdef DEBUG_WR_TIMEOUT_EN
    send_byte(8'h02, s);
    send_byte(8'h05, s);
    repeat (15) begin
      @(posedge clk);
      #1;
    end
    check("to_busy_before", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    exp_err++;
    check("to_busy_after", 32'(busy), 32'd0);
    check("to_err", 32'(err_count), exp_err);
    cmd_set_addr(8'h01, 8'h55);
    payload = '{8'h42, 8'h43};
    cmd_write(8'h02);
`endif

    // Randomized command traffic with random gaps between bytes.
    rand_gap = 1'b1;
    for (int unsigned it = 0; it < 60; it++) begin
      k = $urandom_range(0, 19);
      if (k < 5) begin
        cmd_set_addr(8'($urandom), 8'($urandom));
      end else if (k < 11) begin
        cmd_write(($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(1, 12)));
      end else if (k < 16) begin
        cmd_fill(8'($urandom), ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 40)), 0);
      end else if (k < 19) begin
        op = 8'($urandom_range(5, 255));
        if ($urandom_range(0, 3) == 0) op = 8'h00;
        cmd_bad(op, s);
      end else begin
        cmd_clear(c);
      end
    end
    rand_gap = 1'b0;

    // Error counter saturation.
    for (int unsigned i = 0; i < 260; i++) cmd_bad(8'($urandom_range(5, 255)), s);
    check("err_sat", 32'(err_count), 32'd255);

    guard = 0;
    while (exp_q.size() != 0 && guard < 2000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("drain", exp_q.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
